icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipeline's fetch port and the memory controller's instruction port.
- Serves word fetches on a hit in the same cycle.
- On a miss, it runs a blocking single-word fill from memory and then serves the fetch.
- It also keeps hit and miss counters for performance reporting at halt.

Parameters:
- NSETS, 16, number of one-word frames; must be a power of two.
- IDX_W, 4, log2(NSETS); set index width.
- CNT_W, 32, width of the hit and miss counters.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- imemREN  in  1  fetch request from datapath
- imemaddr  in  32  fetch byte address; bits [1:0] ignored
- ihit  out  1  fetch served this cycle
- imemload  out  32  fetched instruction, valid when ihit=1
- iREN  out  1  read request to memory controller
- iaddr  out  32  word-aligned fill address to memory controller
- iwait  in  1  memory busy; fill word valid when iwait=0 while iREN=1
- iload  in  32  fill data from memory controller
- hit_count  out  CNT_W  number of fetches served without a fill
- miss_count  out  CNT_W  number of fills started

Behaviour:
- Address split: tag = imemaddr[31:IDX_W+2], idx = imemaddr[IDX_W+1:2], offset = [1:0] (ignored).
- Storage per frame: valid bit, tag, and 32-bit data word.
- FSM has two states, IDLE and FILL.
- Reset (RST=1 at an edge):
  - all valid bits cleared;
  - state returns to IDLE;
  - the miss-address register and both counters are cleared;
  - tags and data are don't-care.
  - While RST=1, ihit=0, iREN=0, iaddr=0 and imemload=0.
- IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==tag). It is combinational: ihit=hit and imemload=data[idx] in the same cycle.
  - imemload=0 when ihit=0.
  - On a hit, hit_count increments (saturating at all-ones).
  - On imemREN & !hit: latch {imemaddr[31:2],2'b00} into the miss-address register, increment miss_count (saturating), and go to FILL next cycle.
  - iREN=0 in IDLE.
- FILL:
  - iREN=1 and iaddr=miss-address register; ihit=0.
  - While iwait=1, stay in FILL.
  - When iwait=0, write iload into the frame selected by the latched idx, write the latched tag, set valid, and go to IDLE.
  - The fill-complete cycle itself still reports ihit=0. The refetch hits in the following IDLE cycle.
- Miss latency, from first miss cycle to the ihit cycle: 2 + W cycles, where W is the number of iwait=1 cycles.
- Fills use the latched address only. If imemaddr changes or imemREN drops during FILL, the fill still completes and is installed. This means no abandoned memory request is ever left on the bus.
  - After a fill, the new imemaddr is looked up normally in IDLE.
- Replacement: a fill overwrites the indexed frame unconditionally, including a valid frame holding a different tag.
- Counter policy: counters saturate at all-ones and never wrap. They count only in the cases above, so a stalled repeated request counts once per ihit cycle.
- Reset mid-FILL: the FILL is dropped on the reset edge, iREN deasserts that cycle, and nothing is installed.
  - The memory controller treats iREN deassertion as request cancel.
- imemREN=0 in IDLE: no state change, ihit=0, and no counter change.

Decomposition:
- The following go in cpu_types_pkg next to the existing word_t:
  - icachef_t packed struct {tag, idx, bytoff};
  - ICACHE_IDX_W and ICACHE_TAG_W localparams;
  - icache_frame_t packed struct {valid, tag, data}.
- The FSM state enum (IDLE, FILL) is local to the module.
- One sub-module is natural: icache_frame_array. It holds NSETS icache_frame_t registers, with one combinational read port (idx) and one synchronous write port (wen, widx, frame). It is reset-clearable on valid bits only.

Test Plan:
- Cold miss: reset, then imemREN=1, imemaddr=0x00000040, iwait=1 for 3 cycles then 0 with iload=0x3C010004.
  - Required: iREN=1 and iaddr=0x00000040 during FILL.
  - Required: ihit=1 and imemload=0x3C010004 at cycle 6 (2+3+1). miss_count=1.
- Warm hit: repeat 0x00000040 right after the cold miss above.
  - Required: ihit=1 the same cycle, iREN stays 0, hit_count increments to 2.
- Conflict: after 0x00000040 is installed, fetch 0x00000440 (same idx 0, different tag) with iload=0xAAAA5555.
  - Required: miss, refill, then 0x00000440 hits.
  - Required: a following 0x00000040 misses again (miss_count=3).
- Address change mid-fill: start a miss at 0x00000008, then switch imemaddr to 0x00000010 while iwait=1.
  - Required: iaddr stays 0x00000008 until completion, and frame 2 is installed.
  - Required: 0x00000010 then misses.
- Reset mid-fill: assert RST during FILL.
  - Required: iREN=0 the next cycle, counters=0, and all frames invalid. A refetch of the same address misses.
- Byte offset and saturation: fetch 0x00000043 after 0x00000040 is installed.
  - Required: hits the same word.
  - With CNT_W=4 and 20 hits, hit_count holds at 0xF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word plus instruction-cache address
// split and frame layout. The cache geometry here must agree with the
// NSETS/IDX_W parameters the cache is built with.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // Instruction cache geometry: 16 one-word frames, 4-byte words.
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_BYT_W = 2;
  localparam int ICACHE_TAG_W = WORD_W - ICACHE_IDX_W - ICACHE_BYT_W;

  // Fetch address viewed as {tag, idx, byte offset}.
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [ICACHE_BYT_W-1:0] bytoff;
  } icachef_t;

  // One cache frame: valid bit, stored tag and the cached instruction word.
  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

endpackage

// File: rtl/icache_direct_if.sv
// Bus bundles around the instruction cache: the fetch port toward the
// datapath and the fill port toward the memory controller. Signal names
// follow the datapath/memory-controller naming used elsewhere in the CPU.

// Datapath fetch port: master = datapath, slave = cache.
interface icache_fetch_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;

  modport master (output imemREN, imemaddr, input ihit, imemload);
  modport slave  (input imemREN, imemaddr, output ihit, imemload);
endinterface

// Memory fill port: master = cache, slave = memory controller.
interface icache_mem_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (output iREN, iaddr, input iwait, iload);
  modport slave  (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache_frame_array.sv
// Purpose: NSETS cache frames, one combinational read port, one sync write port.
// Latency: read is same-cycle; a write is visible to reads from the next cycle.
// Backpressure: none; writes are accepted every cycle wen_i is high.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] ridx_i,
  output icache_frame_t    rframe_o,
  input  logic             wen_i,
  input  logic [IDX_W-1:0] widx_i,
  input  icache_frame_t    wframe_i
);

  icache_frame_t frames_q [NSETS];

  assign rframe_o = frames_q[ridx_i];

  // Reset only clears valid bits; tag and data are meaningless until a fill.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NSETS; i++) begin
        frames_q[i].valid <= 1'b0;
      end
    end else if (wen_i) begin
      frames_q[widx_i] <= wframe_i;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Purpose: direct-mapped read-only instruction cache with hit/miss counters.
// Latency: hit served same cycle; miss served 2 + (iwait cycles) after the miss.
// Backpressure: fetch stalls (ihit=0) during a fill; a fill waits on iwait.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  icache_fetch_if.slave    dif,
  icache_mem_if.master     mif,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e           state_q;
  word_t            miss_addr_q;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  icachef_t         req_f;
  icachef_t         fill_f;
  icache_frame_t    rd_frame;
  icache_frame_t    wr_frame;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             lookup;
  logic             hit;
  logic             miss;
  logic             fill_req;
  logic             fill_done;
  logic             unused_bytoff;

  // Address split of the live request and of the latched miss address.
  assign req_f  = icachef_t'(dif.imemaddr);
  assign fill_f = icachef_t'(miss_addr_q);
  assign rd_idx = IDX_W'(req_f.idx);
  assign wr_idx = IDX_W'(fill_f.idx);

  // Byte offset never takes part in lookup or fill.
  assign unused_bytoff = ^{req_f.bytoff, fill_f.bytoff};

  // Lookups only happen in IDLE; reset masks every outward-facing strobe.
  assign lookup    = !RST && (state_q == IDLE) && dif.imemREN;
  assign hit       = lookup && rd_frame.valid && (rd_frame.tag == req_f.tag);
  assign miss      = lookup && !hit;
  assign fill_req  = !RST && (state_q == FILL);
  assign fill_done = fill_req && !mif.iwait;

  assign dif.ihit     = hit;
  assign dif.imemload = hit ? rd_frame.data : '0;
  assign mif.iREN     = fill_req;
  assign mif.iaddr    = fill_req ? miss_addr_q : '0;

  // The fill installs from the latched address, whatever the fetch port
  // is doing now, so the memory request is never abandoned mid-flight.
  assign wr_frame = '{valid: 1'b1, tag: fill_f.tag, data: mif.iload};

  icache_frame_array #(
    .NSETS (NSETS),
    .IDX_W (IDX_W)
  ) u_frames (
    .clk_i    (CLK),
    .rst_i    (RST),
    .ridx_i   (rd_idx),
    .rframe_o (rd_frame),
    .wen_i    (fill_done),
    .widx_i   (wr_idx),
    .wframe_i (wr_frame)
  );

  // Saturating counter next-state: hold at all-ones instead of wrapping.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
    if (miss && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // IDLE/FILL controller with miss-address latch and performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      case (state_q)
        IDLE: begin
          if (miss) begin
            miss_addr_q <= {dif.imemaddr[31:2], 2'b00};
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (fill_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: fetch responses and fill requests are
// queued when issued and checked by independent monitor processes.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_icache_direct;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] hit_count;
  logic [3:0] miss_count;

  icache_fetch_if fif ();
  icache_mem_if   mif ();

  icache_direct #(
    .NSETS (16),
    .IDX_W (4),
    .CNT_W (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .dif        (fif),
    .mif        (mif),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] rsp_q [$];
  logic [31:0] mem_q [$];
  logic [31:0] mem_arr [logic [31:0]];
  int          mem_waits = 0;
  int          wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Count cycles (at negedge) until ihit, bounded; returns to posedge+1.
  task automatic wait_hit(output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge CLK);
      if (fif.ihit) got = 1'b1;
      else lat++;
      @(posedge CLK);
      #1;
    end
  endtask

  // One fetch: queue the expected word (and fill address on a miss),
  // hold the request until served, then check the hit latency.
  task automatic fetch(input logic [31:0] addr, input int waits,
                       input bit exp_miss, input logic [31:0] exp_data);
    int lat;
    mem_waits = waits;
    rsp_q.push_back(exp_data);
    if (exp_miss) mem_q.push_back(addr & 32'hFFFF_FFFC);
    fif.imemREN  = 1'b1;
    fif.imemaddr = addr;
    wait_hit(lat);
    fif.imemREN = 1'b0;
    chk($sformatf("latency_%h", addr), lat, exp_miss ? 2 + waits : 0);
  endtask

  // Fetch-side monitor: every ihit must match the oldest queued response.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge CLK);
      if (fif.ihit) begin
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_hit: got imemload %h, want no hit", fif.imemload);
        end else begin
          exp = rsp_q.pop_front();
          chk("imemload", fif.imemload, exp);
        end
      end
    end
  end

  // Memory controller model: checks each fill cycle's address against the
  // queued expectation, stalls mem_waits cycles, then returns the word.
  initial begin
    mif.iwait = 1'b1;
    mif.iload = '0;
    forever begin
      @(negedge CLK);
      if (mif.iREN) begin
        if (mem_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fill_unexpected: got iaddr %h, want no request", mif.iaddr);
        end else begin
          chk("iaddr", mif.iaddr, mem_q[0]);
        end
        if (wcnt < mem_waits) begin
          mif.iwait = 1'b1;
          wcnt++;
        end else begin
          mif.iwait = 1'b0;
          mif.iload = mem_arr.exists(mif.iaddr) ? mem_arr[mif.iaddr] : 32'hDEAD_BEEF;
          if (mem_q.size() > 0) void'(mem_q.pop_front());
        end
      end else begin
        mif.iwait = 1'b1;
        mif.iload = '0;
        wcnt      = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    fif.imemREN  = 1'b0;
    fif.imemaddr = '0;
    mem_arr[32'h0000_0040] = 32'h3C01_0004;
    mem_arr[32'h0000_0440] = 32'hAAAA_5555;
    mem_arr[32'h0000_0008] = 32'h1111_0008;
    mem_arr[32'h0000_0010] = 32'h2222_0010;
    mem_arr[32'h0000_0020] = 32'h3333_0020;

    // Reset: outputs forced low even with a request present.
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    fif.imemREN  = 1'b1;
    fif.imemaddr = 32'h40;
    @(negedge CLK);
    chk("rst_ihit", fif.ihit, 0);
    chk("rst_iren", mif.iREN, 0);
    chk("rst_iaddr", mif.iaddr, 0);
    chk("rst_imemload", fif.imemload, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    fif.imemREN = 1'b0;
    @(negedge CLK);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("idle_noreq_ihit", fif.ihit, 0);
    @(posedge CLK);
    #1;

    // Cold miss with 3 wait cycles: served at the 6th cycle.
    fetch(32'h40, 3, 1'b1, 32'h3C01_0004);
    chk("cold_miss_count", miss_count, 1);
    chk("cold_hit_count", hit_count, 1);

    // Warm hit: same cycle, no memory request.
    rsp_q.push_back(32'h3C01_0004);
    fif.imemREN  = 1'b1;
    fif.imemaddr = 32'h40;
    @(negedge CLK);
    chk("warm_ihit", fif.ihit, 1);
    chk("warm_iren", mif.iREN, 0);
    @(posedge CLK);
    #1;
    fif.imemREN = 1'b0;
    chk("warm_hit_count", hit_count, 2);

    // Conflict on idx 0: 0x440 evicts 0x40, then 0x40 misses again.
    fetch(32'h440, 1, 1'b1, 32'hAAAA_5555);
    fetch(32'h440, 0, 1'b0, 32'hAAAA_5555);
    fetch(32'h40, 0, 1'b1, 32'h3C01_0004);
    chk("conflict_miss_count", miss_count, 3);
    chk("conflict_hit_count", hit_count, 5);

    // Byte offset ignored.
    fetch(32'h43, 0, 1'b0, 32'h3C01_0004);

    // Address switch mid-fill: 0x08 still installed, then 0x10 misses.
    mem_waits = 4;
    mem_q.push_back(32'h08);
    mem_q.push_back(32'h10);
    rsp_q.push_back(32'h2222_0010);
    fif.imemREN  = 1'b1;
    fif.imemaddr = 32'h08;
    repeat (3) @(posedge CLK);
    #1;
    fif.imemaddr = 32'h10;
    wait_hit(lat);
    fif.imemREN = 1'b0;
    chk("switch_latency", lat + 3, 12);
    chk("switch_miss_count", miss_count, 5);
    chk("switch_hit_count", hit_count, 7);
    fetch(32'h08, 0, 1'b0, 32'h1111_0008);
    chk("frame2_hit_count", hit_count, 8);

    // Reset in the middle of a fill.
    mem_waits = 10;
    mem_q.push_back(32'h20);
    fif.imemREN  = 1'b1;
    fif.imemaddr = 32'h20;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("prefill_iren", mif.iREN, 1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_iren", mif.iREN, 0);
    chk("midrst_iaddr", mif.iaddr, 0);
    chk("midrst_ihit", fif.ihit, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    fif.imemREN = 1'b0;
    mem_q.delete();
    @(negedge CLK);
    chk("postrst_iren", mif.iREN, 0);
    chk("postrst_hit_count", hit_count, 0);
    chk("postrst_miss_count", miss_count, 0);
    @(posedge CLK);
    #1;

    // Every frame invalid after reset.
    fetch(32'h20, 2, 1'b1, 32'h3333_0020);
    fetch(32'h40, 0, 1'b1, 32'h3C01_0004);
    fetch(32'h08, 0, 1'b1, 32'h1111_0008);
    chk("postrst2_miss_count", miss_count, 3);
    chk("postrst2_hit_count", hit_count, 3);

    // Saturation: 20 more hits on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      fetch(32'h40, 0, 1'b0, 32'h3C01_0004);
      if (i == 11) chk("sat_reach", hit_count, 4'hF);
    end
    chk("sat_hold", hit_count, 4'hF);
    chk("sat_miss_count", miss_count, 3);

    repeat (2) @(posedge CLK);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
